icache_way_ram: RTL and testbench

ICACHE_WAY_RAM -- requirements
Module: icache_way_ram

---
 rtl/icache_way_ram.sv | 152 +++++++++++++++
 tb/tb_icache_way_ram.sv | 236 +++++++++++++++++++++++
 2 files changed

// File: rtl/icache_way_ram.sv
// Instruction-cache way storage: a word-addressed data array with byte-enable
// writes and one valid bit per entry, plus an invalidate-all sweep.
//
// Ports
//   clk, rst_n        single rising-edge clock; asynchronous active-low reset
//   wr_en/wr_addr/wr_data/wr_byte_en
//                     byte-masked write; sets the entry's valid bit even with
//                     no byte enabled; dropped entirely while flush_busy=1
//   rd_en/rd_addr     read request
//   rd_data/rd_valid  read result, 1 cycle after rd_en (2 when OUTPUT_REG=1);
//                     holds between reads; write-first on same-address access
//   flush_req         pulse starting an invalidate-all sweep (ignored if busy)
//   flush_busy        high while the sweep runs (one entry cleared per cycle)
//
// Reset puts the block into a sweep, so valid bits need no reset of their own.
module icache_way_ram #(
  parameter int unsigned ADDR_WIDTH = 10,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned BE_WIDTH   = DATA_WIDTH / 8,
  parameter int unsigned OUTPUT_REG = 0
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  wr_en,
  input  logic [ADDR_WIDTH-1:0] wr_addr,
  input  logic [DATA_WIDTH-1:0] wr_data,
  input  logic [BE_WIDTH-1:0]   wr_byte_en,
  input  logic                  rd_en,
  input  logic [ADDR_WIDTH-1:0] rd_addr,
  output logic [DATA_WIDTH-1:0] rd_data,
  output logic                  rd_valid,
  input  logic                  flush_req,
  output logic                  flush_busy
);

  localparam int unsigned Depth = 1 << ADDR_WIDTH;

  typedef enum logic [0:0] {StIdle, StFlush} state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] cnt_q, cnt_d;

  logic [DATA_WIDTH-1:0] mem_q [Depth];
  logic [Depth-1:0]      valid_q;

  logic                  wr_accept;
  logic                  same_addr;
  logic                  sweep_last;
  logic [DATA_WIDTH-1:0] rd_word;
  logic                  rd_word_valid;
  logic [DATA_WIDTH-1:0] rd_data_q;
  logic                  rd_valid_q;

  assign flush_busy = (state_q == StFlush);
  assign wr_accept  = wr_en & ~flush_busy;
  assign same_addr  = wr_accept & (wr_addr == rd_addr);
  assign sweep_last = (cnt_q == {ADDR_WIDTH{1'b1}});

  // Sweep FSM
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      StIdle: begin
        if (flush_req) begin
          state_d = StFlush;
          cnt_d   = '0;
        end
      end
      StFlush: begin
        cnt_d = cnt_q + 1'b1;
        if (sweep_last) state_d = StIdle;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= StFlush;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Data array: never touched by the sweep, only by accepted writes.
  always_ff @(posedge clk) begin
    if (wr_accept) begin
      for (int unsigned b = 0; b < BE_WIDTH; b++) begin
        if (wr_byte_en[b]) mem_q[wr_addr][8*b +: 8] <= wr_data[8*b +: 8];
      end
    end
  end

  // Valid bits: sweep and accepted writes are mutually exclusive.
  always_ff @(posedge clk) begin
    if (flush_busy) begin
      valid_q[cnt_q] <= 1'b0;
    end else if (wr_accept) begin
      valid_q[wr_addr] <= 1'b1;
    end
  end

  // Write-first read: enabled bytes of a same-address write bypass the array.
  always_comb begin
    rd_word = mem_q[rd_addr];
    for (int unsigned b = 0; b < BE_WIDTH; b++) begin
      if (same_addr && wr_byte_en[b]) rd_word[8*b +: 8] = wr_data[8*b +: 8];
    end
    rd_word_valid = ~flush_busy & (same_addr | valid_q[rd_addr]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data_q  <= '0;
      rd_valid_q <= 1'b0;
    end else if (rd_en) begin
      rd_data_q  <= rd_word;
      rd_valid_q <= rd_word_valid;
    end
  end

  if (OUTPUT_REG != 0) begin : gen_out_reg
    logic                  rd_pend_q;
    logic [DATA_WIDTH-1:0] rd_data_q2;
    logic                  rd_valid_q2;

    // Second stage only advances for a read issued the previous cycle, so
    // outputs hold between reads just like the single-stage path.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        rd_pend_q   <= 1'b0;
        rd_data_q2  <= '0;
        rd_valid_q2 <= 1'b0;
      end else begin
        rd_pend_q <= rd_en;
        if (rd_pend_q) begin
          rd_data_q2  <= rd_data_q;
          rd_valid_q2 <= rd_valid_q;
        end
      end
    end

    assign rd_data  = rd_data_q2;
    assign rd_valid = rd_valid_q2;
  end else begin : gen_no_out_reg
    assign rd_data  = rd_data_q;
    assign rd_valid = rd_valid_q;
  end

endmodule

// File: tb/tb_icache_way_ram.sv
module tb_icache_way_ram;

  logic        clk;
  logic        rst_n;
  logic        wr_en;
  logic [3:0]  wr_addr;
  logic [31:0] wr_data;
  logic [3:0]  wr_byte_en;
  logic        rd_en;
  logic [3:0]  rd_addr;
  logic        flush_req;
  logic [31:0] rd_data,  rd_data1;
  logic        rd_valid, rd_valid1;
  logic        flush_busy, flush_busy1;

  icache_way_ram #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BE_WIDTH(4), .OUTPUT_REG(0)
  ) dut (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data),
    .rd_valid(rd_valid), .flush_req(flush_req), .flush_busy(flush_busy)
  );

  icache_way_ram #(
    .ADDR_WIDTH(4), .DATA_WIDTH(32), .BE_WIDTH(4), .OUTPUT_REG(1)
  ) dut_oreg (
    .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .wr_byte_en(wr_byte_en), .rd_en(rd_en), .rd_addr(rd_addr), .rd_data(rd_data1),
    .rd_valid(rd_valid1), .flush_req(flush_req), .flush_busy(flush_busy1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] data;
    logic        valid;
    bit          chk_data;
    string       tag;
  } exp_t;

  exp_t        sb[$];
  int          n_assert = 0;
  int          n_fail   = 0;
  int          busy_seen = 0;

  // Reference model of the way (OUTPUT_REG=0 view).
  logic [31:0] mem_m [16];
  logic [15:0] val_m   = '0;
  logic [15:0] known_m = '0;
  bit          busy_m  = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // One clock; counts cycles that start with flush_busy high.
  task automatic cyc();
    if (flush_busy === 1'b1) busy_seen++;
    @(posedge clk);
    #1;
  endtask

  task automatic wait_sweep();
    int g;
    g = 0;
    while (flush_busy === 1'b1 && g < 40) begin
      cyc();
      g++;
    end
  endtask

  // Drive one cycle's requests and queue the expected read result.
  task automatic drive(input logic wen, input logic [3:0] wa, input logic [31:0] wd,
                       input logic [3:0] be, input logic ren, input logic [3:0] ra,
                       input string tag);
    exp_t e;
    if (ren) begin
      e.tag      = tag;
      e.data     = mem_m[ra];
      e.chk_data = known_m[ra];
      e.valid    = busy_m ? 1'b0 : val_m[ra];
      if (wen && !busy_m && wa == ra) begin
        for (int b = 0; b < 4; b++) if (be[b]) e.data[8*b +: 8] = wd[8*b +: 8];
        e.valid = 1'b1;
        if (be == 4'hF) e.chk_data = 1'b1;
      end
      sb.push_back(e);
    end
    if (wen && !busy_m) begin
      for (int b = 0; b < 4; b++) if (be[b]) mem_m[wa][8*b +: 8] = wd[8*b +: 8];
      val_m[wa]   = 1'b1;
      known_m[wa] = known_m[wa] | (be == 4'hF);
    end
    wr_en = wen; wr_addr = wa; wr_data = wd; wr_byte_en = be;
    rd_en = ren; rd_addr = ra;
  endtask

  task automatic step();
    exp_t e;
    bit   rd;
    rd = rd_en;
    cyc();
    wr_en = 1'b0; rd_en = 1'b0; flush_req = 1'b0;
    if (rd) begin
      if (sb.size() == 0) begin
        chk("sb_empty", 32'd1, 32'd0);
      end else begin
        e = sb.pop_front();
        chk({e.tag, "_valid"}, {31'b0, rd_valid}, {31'b0, e.valid});
        if (e.chk_data) chk({e.tag, "_data"}, rd_data, e.data);
      end
    end
  endtask

  initial begin
    rst_n = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0; wr_byte_en = '0;
    rd_en = 1'b0; rd_addr = '0; flush_req = 1'b0;

    // Asynchronous reset before any clock edge
    #1 rst_n = 1'b0;
    #1;
    chk("rst_rd_data", rd_data, 32'h0);
    chk("rst_rd_valid", {31'b0, rd_valid}, 32'd0);
    chk("rst_busy", {31'b0, flush_busy}, 32'd1);
    chk("rst_oreg_data", rd_data1, 32'h0);

    // Release: 16-cycle sweep, read during sweep is invalid
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    chk("rel_busy", {31'b0, flush_busy}, 32'd1);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd3, "sweep_rd3");
    step();
    wait_sweep();
    chk("reset_sweep_len", busy_seen, 32'd16);
    busy_m = 1'b0; val_m = '0;

    // Full write then read
    drive(1'b1, 4'd5, 32'hDEADBEEF, 4'hF, 1'b0, 4'd0, "");
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, "rd5");
    step();
    chk("rd5_const", rd_data, 32'hDEADBEEF);

    // Same-cycle partial write and read, write-first
    drive(1'b1, 4'd5, 32'h11223344, 4'h3, 1'b1, 4'd5, "wf5");
    step();
    chk("wf5_const", rd_data, 32'hDEAD3344);

    // Outputs hold without rd_en
    step();
    chk("hold_data", rd_data, 32'hDEAD3344);
    chk("hold_valid", {31'b0, rd_valid}, 32'd1);

    // Different addresses same cycle; zero byte enable still validates
    drive(1'b1, 4'd9, 32'h0BADF00D, 4'hF, 1'b1, 4'd5, "diff_rd5");
    step();
    drive(1'b1, 4'd2, 32'hFFFFFFFF, 4'h0, 1'b1, 4'd9, "diff_rd9");
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd2, "be0_rd2");
    step();

    // Flush: write and second flush_req during sweep are ignored
    busy_seen = 0;
    flush_req = 1'b1;
    step();
    busy_m = 1'b1;
    chk("flush_busy", {31'b0, flush_busy}, 32'd1);
    drive(1'b1, 4'd7, 32'h55667788, 4'hF, 1'b0, 4'd0, "");
    step();
    drive(1'b1, 4'd5, 32'h99999999, 4'hF, 1'b1, 4'd5, "flush_rd5");
    flush_req = 1'b1;
    step();
    wait_sweep();
    chk("flush_sweep_len", busy_seen, 32'd16);
    busy_m = 1'b0; val_m = '0;

    // Write on the first cycle after the sweep
    drive(1'b1, 4'd9, 32'hA5A55A5A, 4'hF, 1'b0, 4'd0, "");
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd7, "post_rd7");
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9, "post_rd9");
    step();
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd5, "post_rd5");
    step();
    chk("post_rd5_const", rd_data, 32'hDEAD3344);
    step();
    step();

    // Output register: 2-cycle latency and hold
    chk("oreg_pre_data", rd_data1, 32'hDEAD3344);
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9, "oreg_rd9");
    step();
    chk("oreg_c1_data", rd_data1, 32'hDEAD3344);
    chk("oreg_c1_valid", {31'b0, rd_valid1}, 32'd0);
    step();
    chk("oreg_c2_data", rd_data1, 32'hA5A55A5A);
    chk("oreg_c2_valid", {31'b0, rd_valid1}, 32'd1);
    step();
    step();
    chk("oreg_hold_data", rd_data1, 32'hA5A55A5A);
    chk("oreg_hold_valid", {31'b0, rd_valid1}, 32'd1);
    chk("hold9_data", rd_data, 32'hA5A55A5A);

    // Reset at sweep cycle 8
    flush_req = 1'b1;
    step();
    busy_m = 1'b1;
    repeat (8) cyc();
    #2 rst_n = 1'b0;
    #1;
    chk("mid_rst_data", rd_data, 32'h0);
    chk("mid_rst_valid", {31'b0, rd_valid}, 32'd0);
    chk("mid_rst_busy", {31'b0, flush_busy}, 32'd1);
    chk("mid_rst_oreg_data", rd_data1, 32'h0);
    chk("mid_rst_oreg_busy", {31'b0, flush_busy1}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    busy_seen = 0;
    wait_sweep();
    chk("mid_rst_sweep_len", busy_seen, 32'd16);
    busy_m = 1'b0; val_m = '0; known_m = '0;
    drive(1'b0, 4'd0, 32'h0, 4'h0, 1'b1, 4'd9, "after_rst_rd9");
    step();

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
